vga_line_loader: RTL and testbench
==================================

Name: vga_line_loader

Overview:
- Write-side partner of the VGA controller's line FIFO; replaces the temporary FIFO-writing test logic.
- On each line-load request, latches the requested line number and fetches H_ACTIVE pixels from frame memory over an Avalon-MM style pipelined read port.
- Writes the returned pixels in order into the dual-clock line FIFO, with credit-based flow control against FIFO fill level.
- Runs in the VGA pixel clock domain; the FIFO is written on the inverted clock externally.

Parameters:
- H_ACTIVE, 1280: pixels per line, one FIFO word each.
- LINE_W, 13: width of the line-number input.
- ADDR_W, 25: memory word-address width.
- BASE_ADDR, 0: frame base word address.
- FIFO_DEPTH, 2048: line FIFO depth in words.
- USEDW_W, 11: width of the FIFO write-side used-words input.
- MAX_PENDING, 8: maximum outstanding memory reads (2..15).

Ports:
- iCLK  in  1  pixel clock.
- iRST  in  1  asynchronous reset, active-high.
- iLOAD_REQ  in  1  line-load request level from the VGA controller.
- iLOAD_VLINE  in  LINE_W  requested line number, valid while iLOAD_REQ=1.
- iABORT  in  1  synchronous abort; tied to the FIFO clear signal.
- oMEM_READ  out  1  memory read request.
- oMEM_ADDR  out  ADDR_W  memory word address.
- iMEM_WAITREQUEST  in  1  memory stall.
- iMEM_READDATAVALID  in  1  read data valid.
- iMEM_DATA  in  8  read data.
- oFIFO_WDATA  out  8  FIFO write data.
- oFIFO_WREQ  out  1  FIFO write enable.
- iFIFO_WUSEDW  in  USEDW_W  FIFO words used, write side.
- iFIFO_WFULL  in  1  FIFO full.
- oBUSY  out  1  high in any state other than IDLE.
- oLINE_DONE  out  1  one-cycle pulse when the last pixel of a line is written.
- oOVERRUN  out  1  sticky error flag; cleared only by iRST.

Behaviour:
- Reset: all outputs 0. State returns to IDLE; pending, issue and write counters are cleared.
- States: IDLE, ARM, FETCH, DRAIN, FLUSH.
- IDLE:
  - On iLOAD_REQ=1, latch iLOAD_VLINE into line_q and go to ARM.
- ARM:
  - Wait for iLOAD_REQ=0.
  - On that cycle: set rd_addr = BASE_ADDR + line_q*H_ACTIVE (ADDR_W bits, wraps modulo 2^ADDR_W), clear issue_cnt and wr_cnt, go to FETCH.
- FETCH (issue side):
  - oMEM_READ may rise only when issue_cnt < H_ACTIVE, pending < MAX_PENDING, and iFIFO_WUSEDW + pending + 1 <= FIFO_DEPTH-4, computed at USEDW_W+1 bits.
  - Once raised, oMEM_READ and oMEM_ADDR stay stable until accepted: a cycle with oMEM_READ=1 and iMEM_WAITREQUEST=0.
  - On accept: rd_addr+1, issue_cnt+1, pending+1.
  - Back-to-back accepts are allowed; there is no idle cycle between requests.
- FETCH (return side):
  - Each iMEM_READDATAVALID cycle: oFIFO_WREQ=1 and oFIFO_WDATA=iMEM_DATA in the same cycle (zero-latency pass-through, registered outputs not required), pending-1, wr_cnt+1.
  - Simultaneous accept and return: pending unchanged.
- FETCH → DRAIN when issue_cnt reaches H_ACTIVE.
- DRAIN:
  - Continue writing returns.
  - When wr_cnt reaches H_ACTIVE, pulse oLINE_DONE and go to IDLE.
- Full FIFO:
  - If iFIFO_WFULL=1 when data returns, the write is still issued and oOVERRUN is set. Credit logic makes this unreachable in correct operation.
- New request while busy:
  - iLOAD_REQ rising (0→1 edge) in FETCH or DRAIN sets oOVERRUN and is ignored.
  - The current line completes.
- iABORT:
  - In any non-IDLE state, any in-flight oMEM_READ completes its acceptance first.
  - Then go to FLUSH. In FLUSH, returning data is discarded (oFIFO_WREQ=0) and pending decrements; at pending=0, go to IDLE.
  - No oLINE_DONE is pulsed.
  - iABORT in IDLE: no effect.
- iRST mid-line: immediate return to IDLE. In-flight returns arriving after reset are ignored; they are not counted or written.

Optional Feature:
- Macro: LOADER_TEST_PATTERN_EN.
- Defined:
  - The memory port is held idle (oMEM_READ=0, oMEM_ADDR=0).
  - FETCH produces data internally: one write per cycle while iFIFO_WUSEDW < FIFO_DEPTH-4.
  - Data = wr_cnt[7:0] XOR line_q[7:0].
  - DRAIN and FLUSH are skipped; abort goes straight to IDLE.
- Undefined: memory-backed behaviour as specified above.

Test Plan:
- Zero-wait memory, fixed 3-cycle latency; request line 5 (BASE_ADDR=0) → first address 6400, last 7679; exactly 1280 FIFO writes in address order; one oLINE_DONE; oBUSY falls the same cycle.
- Random iMEM_WAITREQUEST (50%) → oMEM_ADDR/oMEM_READ stable while stalled; no duplicated or skipped address; pending never exceeds 8.
- Hold iFIFO_WUSEDW=2044 → no new oMEM_READ issued; drop to 1000 → issue resumes; oOVERRUN remains 0.
- Pulse iLOAD_REQ for line 7 during FETCH of line 6 → oOVERRUN=1; line 6 completes with 1280 writes; line 7 is not loaded.
- iABORT after 300 accepted reads with 4 pending → zero FIFO writes after abort; IDLE once 4 returns are absorbed; next request line 0 loads addresses 0..1279.
- LOADER_TEST_PATTERN_EN defined, line 3 → FIFO data sequence 3,2,1,0,7,6,…; no oMEM_READ activity.

Source files
------------

// File: rtl/vga_line_loader.sv
// Line loader: fetches one line of 8-bit pixels from frame memory and streams them into the line FIFO.
// Build option LOADER_TEST_PATTERN_EN replaces the memory fetch with an internally generated pattern.
module vga_line_loader #(
   parameter int H_ACTIVE    = 1280,
   parameter int LINE_W      = 13,
   parameter int ADDR_W      = 25,
   parameter int BASE_ADDR   = 0,
   parameter int FIFO_DEPTH  = 2048,
   parameter int USEDW_W     = 11,
   parameter int MAX_PENDING = 8
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iLOAD_REQ,
   input  logic [LINE_W-1:0] iLOAD_VLINE,
   input  logic              iABORT,
   output logic              oMEM_READ,
   output logic [ADDR_W-1:0] oMEM_ADDR,
   input  logic              iMEM_WAITREQUEST,
   input  logic              iMEM_READDATAVALID,
   input  logic [7:0]        iMEM_DATA,
   output logic [7:0]        oFIFO_WDATA,
   output logic              oFIFO_WREQ,
   input  logic [USEDW_W-1:0] iFIFO_WUSEDW,
   input  logic              iFIFO_WFULL,
   output logic              oBUSY,
   output logic              oLINE_DONE,
   output logic              oOVERRUN
);

   localparam int CNT_W  = $clog2(H_ACTIVE + 1);
   localparam int PEND_W = 4;
   localparam int CRED_W = USEDW_W + 1;

   typedef enum logic [2:0] {IDLE, ARM, FETCH, DRAIN, FLUSH} state_t;

   state_t              state_q;
   logic [LINE_W-1:0]   line_q;
   logic [ADDR_W-1:0]   rd_addr_q;
   logic [CNT_W-1:0]    issue_cnt_q, wr_cnt_q;
   logic [PEND_W-1:0]   pending_q;
   logic                mem_read_q, abort_q, req_q, line_done_q, overrun_q;

   logic                in_line, abort_now, accept, ret, wr_en, can_issue, mem_read_d;
   logic [CNT_W-1:0]    issue_cnt_d, wr_cnt_d;
   logic [PEND_W-1:0]   pending_d;
   logic [CRED_W-1:0]   credit_sum;

   assign in_line   = (state_q == FETCH) || (state_q == DRAIN);
   assign abort_now = (iABORT || abort_q) && (state_q != IDLE);

`ifdef LOADER_TEST_PATTERN_EN
   localparam bit TEST_PATTERN = 1'b1;
   logic unused_mem;
   assign unused_mem  = ^{iMEM_WAITREQUEST, iMEM_READDATAVALID, iMEM_DATA, rd_addr_q};
   assign accept      = 1'b0;
   assign ret         = 1'b0;
   assign wr_en       = (state_q == FETCH) && !abort_now &&
                        (iFIFO_WUSEDW < USEDW_W'(FIFO_DEPTH - 4));
   assign oFIFO_WDATA = wr_cnt_q[7:0] ^ line_q[7:0];
   assign oMEM_ADDR   = '0;
`else
   localparam bit TEST_PATTERN = 1'b0;
   assign accept      = mem_read_q && !iMEM_WAITREQUEST;
   // Returns with nothing outstanding are leftovers from before a reset.
   assign ret         = iMEM_READDATAVALID && (pending_q != '0);
   assign wr_en       = ret && in_line && !abort_now;
   assign oFIFO_WDATA = iMEM_DATA;
   assign oMEM_ADDR   = rd_addr_q;
`endif

   assign issue_cnt_d = issue_cnt_q + CNT_W'(accept);
   assign wr_cnt_d    = wr_cnt_q + CNT_W'(wr_en);

   always_comb begin
      pending_d = pending_q;
      if (accept && !ret)
         pending_d = pending_q + 1'b1;
      else if (!accept && ret)
         pending_d = pending_q - 1'b1;
   end

   // Credit is judged on the post-update counts so requests can issue back to back.
   assign credit_sum = CRED_W'(iFIFO_WUSEDW) + CRED_W'(pending_d) + CRED_W'(1);
   assign can_issue  = !TEST_PATTERN && (state_q == FETCH) && !abort_now &&
                       (issue_cnt_d < CNT_W'(H_ACTIVE)) &&
                       (pending_d < PEND_W'(MAX_PENDING)) &&
                       (credit_sum <= CRED_W'(FIFO_DEPTH - 4));
   assign mem_read_d = (mem_read_q && !accept) ? 1'b1 : can_issue;

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q     <= IDLE;
         line_q      <= '0;
         rd_addr_q   <= '0;
         issue_cnt_q <= '0;
         wr_cnt_q    <= '0;
         pending_q   <= '0;
         mem_read_q  <= 1'b0;
         abort_q     <= 1'b0;
         req_q       <= 1'b0;
         line_done_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         req_q       <= iLOAD_REQ;
         line_done_q <= 1'b0;
         pending_q   <= pending_d;
         mem_read_q  <= mem_read_d;
         issue_cnt_q <= issue_cnt_d;
         wr_cnt_q    <= wr_cnt_d;
         if (accept)
            rd_addr_q <= rd_addr_q + 1'b1;
         if ((wr_en && iFIFO_WFULL) || (in_line && iLOAD_REQ && !req_q))
            overrun_q <= 1'b1;

         case (state_q)
            IDLE: begin
               abort_q <= 1'b0;
               if (iLOAD_REQ) begin
                  line_q  <= iLOAD_VLINE;
                  state_q <= ARM;
               end
            end
            ARM: begin
               if (abort_now) begin
                  if (TEST_PATTERN) state_q <= IDLE;
                  else              state_q <= FLUSH;
               end else if (!iLOAD_REQ) begin
                  rd_addr_q   <= ADDR_W'(BASE_ADDR) + ADDR_W'(line_q) * ADDR_W'(H_ACTIVE);
                  issue_cnt_q <= '0;
                  wr_cnt_q    <= '0;
                  state_q     <= FETCH;
               end
            end
            FETCH, DRAIN: begin
               if (abort_now) begin
                  // A request already on the bus must be accepted before flushing.
                  if (TEST_PATTERN) begin
                     state_q <= IDLE;
                     abort_q <= 1'b0;
                  end else if (!mem_read_q || accept) begin
                     state_q <= FLUSH;
                     abort_q <= 1'b0;
                  end else begin
                     abort_q <= 1'b1;
                  end
               end else if (wr_cnt_d == CNT_W'(H_ACTIVE)) begin
                  line_done_q <= 1'b1;
                  state_q     <= IDLE;
               end else if ((state_q == FETCH) && (issue_cnt_d == CNT_W'(H_ACTIVE))) begin
                  state_q <= DRAIN;
               end
            end
            FLUSH: begin
               if (pending_d == '0)
                  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign oMEM_READ  = mem_read_q;
   assign oFIFO_WREQ = wr_en;
   assign oBUSY      = (state_q != IDLE);
   assign oLINE_DONE = line_done_q;
   assign oOVERRUN   = overrun_q;

endmodule

// File: tb/tb_vga_line_loader.sv
// Scoreboard bench for vga_line_loader: memory model with programmable latency/stalls,
// expected FIFO writes queued per line load and checked by an independent monitor.
module tb_vga_line_loader;
   localparam int H_ACTIVE = 1280;
   localparam int LINE_W   = 13;
   localparam int ADDR_W   = 25;
   localparam int USEDW_W  = 11;
   localparam int BUDGET   = 20000;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               load_req = 1'b0;
   logic [LINE_W-1:0]  load_vline = '0;
   logic               abort = 1'b0;
   logic               mem_read;
   logic [ADDR_W-1:0]  mem_addr;
   logic               waitreq = 1'b0;
   logic               rdvalid = 1'b0;
   logic [7:0]         mem_data = 8'h00;
   logic [7:0]         fifo_wdata;
   logic               fifo_wreq;
   logic [USEDW_W-1:0] usedw = '0;
   logic               wfull = 1'b0;
   logic               busy, line_done, overrun;

   vga_line_loader #(
      .H_ACTIVE(H_ACTIVE), .LINE_W(LINE_W), .ADDR_W(ADDR_W), .BASE_ADDR(0),
      .FIFO_DEPTH(2048), .USEDW_W(USEDW_W), .MAX_PENDING(8)
   ) dut (
      .iCLK(clk), .iRST(rst), .iLOAD_REQ(load_req), .iLOAD_VLINE(load_vline),
      .iABORT(abort), .oMEM_READ(mem_read), .oMEM_ADDR(mem_addr),
      .iMEM_WAITREQUEST(waitreq), .iMEM_READDATAVALID(rdvalid), .iMEM_DATA(mem_data),
      .oFIFO_WDATA(fifo_wdata), .oFIFO_WREQ(fifo_wreq), .iFIFO_WUSEDW(usedw),
      .iFIFO_WFULL(wfull), .oBUSY(busy), .oLINE_DONE(line_done), .oOVERRUN(overrun)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int lat = 3;
   bit rand_wait = 1'b0;
   bit no_writes = 1'b0;
   int ret_due[$];
   logic [ADDR_W-1:0] ret_addr[$];
   logic [7:0] exp_q[$];
   logic [ADDR_W-1:0] exp_addr = '0;
   int n_accept = 0, n_write = 0, n_done = 0, outstanding = 0, max_out = 0;
   bit prev_stall = 1'b0;
   logic [ADDR_W-1:0] prev_addr = '0;

   function automatic logic [7:0] mem_word(input logic [ADDR_W-1:0] a);
      return a[7:0] ^ a[15:8];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Memory model: applies stalls and returns data for accepted reads after lat cycles.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         waitreq = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
         if (ret_due.size() > 0 && ret_due[0] == cyc + 1) begin
            rdvalid  = 1'b1;
            mem_data = mem_word(ret_addr.pop_front());
            void'(ret_due.pop_front());
         end else begin
            rdvalid  = 1'b0;
            mem_data = 8'h00;
         end
      end
   end

   // Monitor: observes the upcoming clock edge's transfers and scores FIFO writes.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("stall_read_hold", 32'(mem_read), 32'd1);
               check("stall_addr_hold", 32'(mem_addr), 32'(prev_addr));
            end
            prev_stall = mem_read && waitreq;
            prev_addr  = mem_addr;
            if (mem_read && !waitreq) begin
               check("addr_order", 32'(mem_addr), 32'(exp_addr));
               exp_addr = exp_addr + 1'b1;
               n_accept++;
               outstanding++;
               ret_due.push_back(cyc + 1 + lat);
               ret_addr.push_back(mem_addr);
            end
            if (rdvalid) outstanding--;
            if (outstanding > max_out) max_out = outstanding;
            if (fifo_wreq) begin
               n_write++;
               if (no_writes || exp_q.size() == 0)
                  check("unexpected_write", 32'(fifo_wreq), 32'd0);
               else
                  check("fifo_wdata", 32'(fifo_wdata), 32'(exp_q.pop_front()));
            end
            if (line_done) begin
               n_done++;
               check("busy_at_done", 32'(busy), 32'd0);
            end
         end
      end
   end

   task automatic start_line(input int line);
      exp_addr = ADDR_W'(line * H_ACTIVE);
      for (int i = 0; i < H_ACTIVE; i++) begin
`ifdef LOADER_TEST_PATTERN_EN
         exp_q.push_back(8'(i) ^ 8'(line));
`else
         exp_q.push_back(mem_word(exp_addr + ADDR_W'(i)));
`endif
      end
      @(posedge clk); #1;
      load_vline = LINE_W'(line);
      load_req   = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      load_req = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      @(posedge clk); #1;
      while (busy && n < BUDGET) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_idle_timeout"}, 32'(busy), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic wait_accepts(input string name, input int target);
      int n = 0;
      while (n_accept < target && n < BUDGET) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_accept_timeout"}, 32'(n_accept >= target), 32'd1);
   endtask

   initial begin
      int w0, d0, a0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs",
            32'({mem_read, mem_addr, fifo_wreq, busy, line_done, overrun}), 32'd0);
      rst = 1'b0;

`ifdef LOADER_TEST_PATTERN_EN
      w0 = n_write; d0 = n_done; a0 = n_accept;
      start_line(3);
      wait_idle("tp");
      check("tp_writes", 32'(n_write - w0), 32'd1280);
      check("tp_done", 32'(n_done - d0), 32'd1);
      check("tp_no_mem_read", 32'(n_accept - a0), 32'd0);
      check("tp_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] pattern line 3: %0d writes", n_write - w0);
`else
      // Zero-wait memory, 3-cycle latency, line 5 -> addresses 6400..7679.
      w0 = n_write; d0 = n_done; max_out = 0;
      start_line(5);
      wait_idle("t1");
      check("t1_writes", 32'(n_write - w0), 32'd1280);
      check("t1_done", 32'(n_done - d0), 32'd1);
      check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
      check("t1_pending_max", 32'(max_out <= 8), 32'd1);
      $display("[TB] line 5 zero-wait: %0d writes, max pending %0d", n_write - w0, max_out);

      // Random stalls.
      w0 = n_write; d0 = n_done; max_out = 0; rand_wait = 1'b1;
      start_line(9);
      wait_idle("t2");
      rand_wait = 1'b0;
      check("t2_writes", 32'(n_write - w0), 32'd1280);
      check("t2_done", 32'(n_done - d0), 32'd1);
      check("t2_pending_max", 32'(max_out <= 8), 32'd1);
      $display("[TB] line 9 random stall: %0d writes, max pending %0d", n_write - w0, max_out);

      // FIFO near full holds off issue until it drains.
      w0 = n_write; a0 = n_accept; usedw = 11'd2044;
      start_line(2);
      repeat (40) begin @(posedge clk); #1; end
      check("t3_no_issue", 32'(n_accept - a0), 32'd0);
      check("t3_busy_held", 32'(busy), 32'd1);
      usedw = 11'd1000;
      wait_idle("t3");
      check("t3_writes", 32'(n_write - w0), 32'd1280);
      check("t3_overrun", 32'(overrun), 32'd0);
      $display("[TB] line 2 credit hold: %0d writes", n_write - w0);

      // New request while fetching is flagged and ignored.
      w0 = n_write; d0 = n_done; a0 = n_accept;
      start_line(6);
      wait_accepts("t4", a0 + 100);
      load_vline = LINE_W'(7);
      load_req = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      load_req = 1'b0;
      @(posedge clk); #1;
      check("t4_overrun_set", 32'(overrun), 32'd1);
      wait_idle("t4");
      check("t4_writes", 32'(n_write - w0), 32'd1280);
      check("t4_done", 32'(n_done - d0), 32'd1);
      a0 = n_accept;
      repeat (50) begin @(posedge clk); #1; end
      check("t4_no_line7", 32'(n_accept - a0), 32'd0);
      check("t4_idle", 32'(busy), 32'd0);
      $display("[TB] line 6 with overlapping request: %0d writes", n_write - w0);
      rst = 1'b1;
      @(posedge clk); #1;
      check("t4_reset_clears_overrun", 32'(overrun), 32'd0);
      rst = 1'b0;

      // Abort mid-line after 300 accepts, then load line 0.
      d0 = n_done; a0 = n_accept; lat = 4;
      start_line(4);
      wait_accepts("t5", a0 + 300);
      abort = 1'b1;
      no_writes = 1'b1;
      exp_q.delete();
      $display("[TB] abort after %0d accepts with %0d outstanding", n_accept - a0, outstanding);
      @(posedge clk); #1;
      abort = 1'b0;
      wait_idle("t5");
      check("t5_outstanding", 32'(outstanding), 32'd0);
      check("t5_no_done", 32'(n_done - d0), 32'd0);
      no_writes = 1'b0;
      lat = 3;
      w0 = n_write; d0 = n_done;
      start_line(0);
      wait_idle("t5b");
      check("t5_line0_writes", 32'(n_write - w0), 32'd1280);
      check("t5_line0_done", 32'(n_done - d0), 32'd1);
      check("t5_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] line 0 after abort: %0d writes", n_write - w0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
